data_mem_ctrl: RTL and testbench



---
 rtl/data_mem_ctrl_pkg.sv | 47 ++++
 rtl/mem_lane_align.sv | 60 ++++++
 rtl/data_mem_ctrl.sv | 174 +++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and helpers for the MEM-stage data memory controller.
// Access sizes, MIPS exception codes, controller states and the cached attribute.
package data_mem_ctrl_pkg;

  typedef logic [31:0] word_t;
  typedef logic [2:0]  triblebit_t;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_MOD  = 5'd1,
    EXC_TLBL = 5'd2,
    EXC_TLBS = 5'd3,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5
  } exc_code_t;

  typedef enum logic [2:0] {
    DMEM_IDLE,
    DMEM_BUS,
    DMEM_DONE,
    DMEM_EXC,
    DMEM_DROP
  } dmem_state_t;

  localparam triblebit_t CACHE_ATTR_CACHED = 3'b011;

  // Size code 3 is handled exactly like a word access.
  function automatic logic size_is_word(input logic [1:0] size);
    return size[1];
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
    if (size_is_word(size))
      return addr != 2'b00;
    else if (size == MEM_HALF)
      return addr[0];
    else
      return 1'b0;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores (enables + replicated data) and lane
// extraction with sign/zero extension for loads. Purely combinational.
module mem_lane_align
  import data_mem_ctrl_pkg::*;
(
  input  logic [1:0] st_size,
  input  logic [1:0] st_addr,
  input  word_t      st_wdata,
  output logic [3:0] st_be,
  output word_t      st_wdata_lanes,
  input  logic [1:0] ld_size,
  input  logic [1:0] ld_addr,
  input  logic       ld_unsigned,
  input  word_t      ld_rdata,
  output word_t      ld_rdata_ext
);

  logic st_word;
  logic st_half;
  assign st_word = size_is_word(st_size);
  assign st_half = (st_size == MEM_HALF);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE     = 2'(gi);
      localparam int         HALF_OFS = (gi % 2) * 8;

      assign st_be[gi] = st_word ? 1'b1 :
                         st_half ? (st_addr[1] == LANE[1]) :
                                   (st_addr == LANE);

      assign st_wdata_lanes[gi*8 +: 8] = st_word ? st_wdata[gi*8 +: 8] :
                                         st_half ? st_wdata[HALF_OFS +: 8] :
                                                   st_wdata[7:0];
    end
  endgenerate

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = ld_rdata[7:0];
    case (ld_addr)
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      2'd3:    ld_byte = ld_rdata[31:24];
      default: ld_byte = ld_rdata[7:0];
    endcase
    ld_half = ld_addr[1] ? ld_rdata[31:16] : ld_rdata[15:0];

    ld_rdata_ext = ld_rdata;
    if (size_is_word(ld_size))
      ld_rdata_ext = ld_rdata;
    else if (ld_size == MEM_HALF)
      ld_rdata_ext = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
    else
      ld_rdata_ext = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data access controller: checks MMU/alignment faults, runs one
// handshaked bus transaction per request and stalls the pipeline until done.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  word_t       req_vaddr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  input  logic [31:0] data_paddr,
  input  logic        miss2,
  input  logic        v2,
  input  logic        d2,
  input  logic        illegal2,
  input  triblebit_t  c2,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_uncached,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic        exc_refill,
  output logic [31:0] exc_badvaddr
);

  dmem_state_t state_reg, state_next;

  logic        bus_we_reg;
  logic [3:0]  bus_be_reg;
  logic [31:0] bus_addr_reg;
  logic [31:0] bus_wdata_reg;
  logic        bus_uncached_reg;
  logic [1:0]  size_reg;
  logic        unsigned_reg;
  logic [1:0]  lane_reg;
  logic [31:0] resp_rdata_reg;
  exc_code_t   exc_code_reg;
  logic        exc_refill_reg;
  logic [31:0] exc_badvaddr_reg;

  logic        accept;
  logic        fault;
  exc_code_t   fault_code;
  logic        fault_refill;
  logic [3:0]  st_be;
  word_t       st_wdata_lanes;
  word_t       ld_rdata_ext;

  mem_lane_align u_lane_align (
    .st_size        (req_size),
    .st_addr        (data_paddr[1:0]),
    .st_wdata       (req_wdata),
    .st_be          (st_be),
    .st_wdata_lanes (st_wdata_lanes),
    .ld_size        (size_reg),
    .ld_addr        (lane_reg),
    .ld_unsigned    (unsigned_reg),
    .ld_rdata       (bus_rdata),
    .ld_rdata_ext   (ld_rdata_ext)
  );

  assign accept = (state_reg == DMEM_IDLE) && req_valid && !flush;

  // Fault priority: address error, TLB refill miss, invalid entry, store to clean page.
  always_comb begin
    fault        = 1'b0;
    fault_code   = EXC_INT;
    fault_refill = 1'b0;
    if (misaligned(req_size, req_vaddr[1:0]) || illegal2) begin
      fault      = 1'b1;
      fault_code = req_we ? EXC_ADES : EXC_ADEL;
    end else if (miss2) begin
      fault        = 1'b1;
      fault_code   = req_we ? EXC_TLBS : EXC_TLBL;
      fault_refill = 1'b1;
    end else if (!v2) begin
      fault      = 1'b1;
      fault_code = req_we ? EXC_TLBS : EXC_TLBL;
    end else if (req_we && !d2) begin
      fault      = 1'b1;
      fault_code = EXC_MOD;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DMEM_IDLE: begin
        if (accept)
          state_next = fault ? DMEM_EXC : DMEM_BUS;
      end
      DMEM_BUS: begin
        if (bus_ack)
          state_next = DMEM_DONE;
        else if (flush)
          state_next = DMEM_DROP;
      end
      DMEM_DONE: state_next = DMEM_IDLE;
      DMEM_EXC:  state_next = DMEM_IDLE;
      // A request already on the bus must see its ack before we let go.
      DMEM_DROP: begin
        if (bus_ack)
          state_next = DMEM_IDLE;
      end
      default:   state_next = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= DMEM_IDLE;
      bus_we_reg       <= 1'b0;
      bus_be_reg       <= 4'b0000;
      bus_addr_reg     <= 32'd0;
      bus_wdata_reg    <= 32'd0;
      bus_uncached_reg <= 1'b0;
      size_reg         <= 2'd0;
      unsigned_reg     <= 1'b0;
      lane_reg         <= 2'd0;
      resp_rdata_reg   <= 32'd0;
      exc_code_reg     <= EXC_INT;
      exc_refill_reg   <= 1'b0;
      exc_badvaddr_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (accept && fault) begin
        exc_code_reg     <= fault_code;
        exc_refill_reg   <= fault_refill;
        exc_badvaddr_reg <= req_vaddr;
      end
      if (accept && !fault) begin
        bus_we_reg       <= req_we;
        bus_be_reg       <= st_be;
        bus_addr_reg     <= {data_paddr[31:2], 2'b00};
        bus_wdata_reg    <= st_wdata_lanes;
        bus_uncached_reg <= (c2 != CACHE_ATTR_CACHED);
        size_reg         <= req_size;
        unsigned_reg     <= req_unsigned;
        lane_reg         <= data_paddr[1:0];
      end
      if (state_reg == DMEM_BUS && bus_ack)
        resp_rdata_reg <= bus_we_reg ? 32'd0 : ld_rdata_ext;
    end
  end

  assign bus_req      = (state_reg == DMEM_BUS) || (state_reg == DMEM_DROP);
  assign bus_we       = bus_we_reg;
  assign bus_be       = bus_be_reg;
  assign bus_addr     = bus_addr_reg;
  assign bus_wdata    = bus_wdata_reg;
  assign bus_uncached = bus_uncached_reg;

  assign resp_valid   = (state_reg == DMEM_DONE) || (state_reg == DMEM_EXC);
  assign exc_valid    = (state_reg == DMEM_EXC);
  assign resp_rdata   = (state_reg == DMEM_DONE) ? resp_rdata_reg : 32'd0;
  assign exc_code     = exc_valid ? exc_code_reg : EXC_INT;
  assign exc_refill   = exc_valid && exc_refill_reg;
  assign exc_badvaddr = exc_valid ? exc_badvaddr_reg : 32'd0;

  assign stall = req_valid && !resp_valid;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: loads, stores, fault priority, flush and reset.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_unsigned, flush;
  logic [1:0]  req_size;
  logic [31:0] req_vaddr, req_wdata, data_paddr;
  logic        miss2, v2, d2, illegal2;
  logic [2:0]  c2;
  logic        bus_req, bus_we, bus_uncached, bus_ack;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        stall, resp_valid, exc_valid, exc_refill;
  logic [31:0] resp_rdata, exc_badvaddr;
  logic [4:0]  exc_code;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  data_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_vaddr(req_vaddr), .req_wdata(req_wdata),
    .flush(flush), .data_paddr(data_paddr),
    .miss2(miss2), .v2(v2), .d2(d2), .illegal2(illegal2), .c2(c2),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_uncached(bus_uncached),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_refill(exc_refill),
    .exc_badvaddr(exc_badvaddr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end else
      $display("ok   %s: %h", tag, got);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flags_ok();
    miss2 = 1'b0; v2 = 1'b1; d2 = 1'b1; illegal2 = 1'b0;
  endtask

  // Full successful access: ack arrives after wait_cyc extra BUS cycles.
  task automatic access(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] vaddr, input logic [31:0] paddr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int wait_cyc,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic exp_unc, input logic [31:0] exp_rdata);
    flags_ok();
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_vaddr = vaddr; data_paddr = paddr; req_wdata = wdata;
    #1;
    check({tag, ".stall_pre"}, 32'(stall), 32'd1);
    tick();
    check({tag, ".bus_req"},  32'(bus_req), 32'd1);
    check({tag, ".bus_addr"}, bus_addr, {paddr[31:2], 2'b00});
    check({tag, ".bus_be"},   32'(bus_be), 32'(exp_be));
    check({tag, ".bus_wdata"}, bus_wdata, exp_wdata);
    check({tag, ".bus_we"},   32'(bus_we), 32'(we));
    check({tag, ".bus_unc"},  32'(bus_uncached), 32'(exp_unc));
    for (int i = 0; i < wait_cyc; i++) begin
      tick();
      check({tag, ".req_hold"}, {30'd0, bus_req, resp_valid}, 32'd2);
    end
    bus_ack = 1'b1; bus_rdata = rdata;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'd0;
    check({tag, ".resp"},      {29'd0, resp_valid, exc_valid, bus_req}, 32'd4);
    check({tag, ".rdata"},     resp_rdata, exp_rdata);
    check({tag, ".stall_end"}, 32'(stall), 32'd0);
    req_valid = 1'b0;
    tick();
    check({tag, ".resp_off"},  32'(resp_valid), 32'd0);
  endtask

  task automatic fault(input string tag, input logic we, input logic [1:0] size,
                       input logic [31:0] vaddr, input logic m, input logic v, input logic d,
                       input logic ill, input logic [4:0] exp_code, input logic exp_refill);
    miss2 = m; v2 = v; d2 = d; illegal2 = ill;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = 1'b0;
    req_vaddr = vaddr; data_paddr = {3'b000, vaddr[28:0]}; req_wdata = 32'hDEADBEEF;
    tick();
    check({tag, ".flags"},  {29'd0, resp_valid, exc_valid, bus_req}, 32'd6);
    check({tag, ".code"},   32'(exc_code), 32'(exp_code));
    check({tag, ".refill"}, 32'(exc_refill), 32'(exp_refill));
    check({tag, ".badva"},  exc_badvaddr, vaddr);
    check({tag, ".rdata"},  resp_rdata, 32'd0);
    req_valid = 1'b0; flags_ok();
    tick();
    check({tag, ".after"},  {30'd0, resp_valid, bus_req}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ctl"},   {17'd0, bus_req, bus_we, bus_be, bus_uncached, resp_valid,
                            exc_valid, exc_code, exc_refill}, 32'd0);
    check({tag, ".addr"},  bus_addr, 32'd0);
    check({tag, ".wdata"}, bus_wdata, 32'd0);
    check({tag, ".rdata"}, resp_rdata, 32'd0);
    check({tag, ".badva"}, exc_badvaddr, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_vaddr = 32'd0; req_wdata = 32'd0; flush = 1'b0; data_paddr = 32'd0;
    c2 = 3'b011; bus_ack = 1'b0; bus_rdata = 32'd0;
    flags_ok();
    tick(); tick();
    rst = 1'b0;
    check_all_zero("reset");
    check("reset.stall", 32'(stall), 32'd0);

    access("ld_word", 1'b0, 2'd2, 1'b0, 32'h80001000, 32'h00001000, 32'd0, 32'h8899AABB, 2,
           4'hF, 32'd0, 1'b0, 32'h8899AABB);
    access("ld_byte_s", 1'b0, 2'd0, 1'b0, 32'h80002002, 32'h00002002, 32'd0, 32'h00850000, 0,
           4'b0100, 32'd0, 1'b0, 32'hFFFFFF85);
    access("ld_byte_u", 1'b0, 2'd0, 1'b1, 32'h80002002, 32'h00002002, 32'd0, 32'h00850000, 1,
           4'b0100, 32'd0, 1'b0, 32'h00000085);
    access("ld_half_s", 1'b0, 2'd1, 1'b0, 32'h80003002, 32'h00003002, 32'd0, 32'h80017FFF, 0,
           4'b1100, 32'd0, 1'b0, 32'hFFFF8001);
    access("ld_half_u0", 1'b0, 2'd1, 1'b1, 32'h80003000, 32'h00003000, 32'd0, 32'h80019234, 0,
           4'b0011, 32'd0, 1'b0, 32'h00009234);
    access("st_half", 1'b1, 2'd1, 1'b0, 32'h80001002, 32'h00001002, 32'h1234ABCD, 32'hFFFFFFFF, 1,
           4'b1100, 32'hABCDABCD, 1'b0, 32'd0);
    c2 = 3'b010;
    access("st_byte3", 1'b1, 2'd0, 1'b0, 32'hA0004003, 32'h00004003, 32'h000000A5, 32'd0, 0,
           4'b1000, 32'hA5A5A5A5, 1'b1, 32'd0);
    access("st_word_sz3", 1'b1, 2'd3, 1'b0, 32'hA0004008, 32'h00004008, 32'hCAFEF00D, 32'd0, 0,
           4'b1111, 32'hCAFEF00D, 1'b1, 32'd0);
    c2 = 3'b011;

    fault("st_miss",   1'b1, 2'd2, 32'h00400010, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1);
    fault("st_inval",  1'b1, 2'd2, 32'h00400014, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0);
    fault("st_clean",  1'b1, 2'd2, 32'h00400018, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0);
    fault("ld_misal",  1'b0, 2'd2, 32'h00400022, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0);
    fault("ld_miss",   1'b0, 2'd0, 32'h00400023, 1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1);
    fault("st_h_odd",  1'b1, 2'd1, 32'h00400031, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0);
    fault("ld_illeg",  1'b0, 2'd2, 32'hC0000040, 1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0);

    // Flush while the bus request is outstanding.
    flags_ok();
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_vaddr = 32'h80005000; data_paddr = 32'h00005000;
    tick();
    check("flush.bus_req", 32'(bus_req), 32'd1);
    flush = 1'b1; req_valid = 1'b0;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("flush.hold", {30'd0, bus_req, resp_valid}, 32'd2);
      tick();
    end
    bus_ack = 1'b1; bus_rdata = 32'h11112222;
    check("flush.hold_ack", 32'(bus_req), 32'd1);
    tick();
    bus_ack = 1'b0;
    check("flush.idle", {30'd0, bus_req, resp_valid}, 32'd0);
    tick();
    check("flush.noresp", 32'(resp_valid), 32'd0);
    access("post_flush", 1'b0, 2'd2, 1'b0, 32'h80006004, 32'h00006004, 32'd0, 32'h0BADF00D, 0,
           4'hF, 32'd0, 1'b0, 32'h0BADF00D);

    // Reset while in BUS.
    c2 = 3'b000;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
    req_vaddr = 32'h80007008; data_paddr = 32'h00007008; req_wdata = 32'h55AA55AA;
    tick();
    check("rstbus.bus_req", 32'(bus_req), 32'd1);
    req_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; c2 = 3'b011;
    check_all_zero("rstbus");
    access("post_rst", 1'b0, 2'd0, 1'b0, 32'h80008001, 32'h00008001, 32'd0, 32'h00007F00, 0,
           4'b0010, 32'd0, 1'b0, 32'h0000007F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
